// File: rtl/bb_cmd_pkg.sv
// bb_cmd_pkg: definitions shared by the command-frame link.
// Holds the default check offset, the command ids and the receiver FSM encodings.
package bb_cmd_pkg;

  // Default check byte offset: chk = id + CHK_OFFSET (mod 256).
  localparam logic [7:0] CHK_OFFSET_DEF = 8'hB3;

  // Command ids carried in the id byte.
  localparam logic [7:0] CMD_CLOSE = 8'h01;
  localparam logic [7:0] CMD_OPEN  = 8'h02;
  localparam logic [7:0] CMD_LY    = 8'h03;
  localparam logic [7:0] CMD_BC    = 8'h04;
  localparam logic [7:0] CMD_NH    = 8'h05;

  // Byte-level receiver states.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Frame-level states: waiting for the id byte or for its check byte.
  typedef enum logic {
    FR_WAIT_ID  = 1'b0,
    FR_WAIT_CHK = 1'b1
  } frame_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: input synchroniser, baud counter and 8N1 byte FSM.
// Emits one-cycle byte_done / byte_err pulses; byte_data holds the last byte.
// The FSM leaves at the stop-bit centre so a back-to-back start edge is caught.
module uart_rx_byte
  import bb_cmd_pkg::*;
#(
  parameter int BIT_CNT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_rx,
  output logic [7:0] byte_data,
  output logic       byte_done,
  output logic       byte_err,
  output logic       busy
);

  localparam int CW = (BIT_CNT > 2) ? $clog2(BIT_CNT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CNT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BIT_CNT - 1);

  logic [1:0]    sync_q;
  logic          prev_q;
  logic          line_s;
  logic          fall;
  rx_state_e     state_q;
  rx_state_e     state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    data_q;
  logic          done_q;
  logic          err_q;
  logic          tick_half;
  logic          tick_full;
  logic          cnt_clr;
  logic          shift_en;
  logic          done_set;
  logic          err_set;

  // Two-flop synchroniser plus a history flop for falling-edge detection, all idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the chain shifts by one stage per clock.
      sync_q <= {sync_q[0], line_rx};
      prev_q <= sync_q[1];
    end
  end

  assign line_s    = sync_q[1];
  assign fall      = prev_q & ~line_s;
  assign tick_half = (cnt_q == HALF_LAST);
  assign tick_full = (cnt_q == FULL_LAST);

  // Byte FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RX_IDLE;
    else        state_q <= state_d;
  end

  // Byte FSM next state: start qualified at half a bit, data and stop at bit centres.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (fall) state_d = RX_START;
      RX_START: if (tick_half) state_d = line_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_full && bit_idx_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (tick_full) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // Byte FSM outputs: counter restart, data shift and end-of-byte result.
  always_comb begin
    // NOTE: each signal gets a default before the case so no path leaves it unassigned and no latch is inferred.
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      RX_IDLE:  cnt_clr = 1'b1;
      RX_START: cnt_clr = tick_half;
      RX_DATA: begin
        cnt_clr  = tick_full;
        shift_en = tick_full;
      end
      RX_STOP: begin
        done_set = tick_full & line_s;
        err_set  = tick_full & ~line_s;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Baud counter, bit index, LSB-first shift register and registered result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_clr ? '0 : cnt_q + CW'(1);
      if (state_q != RX_DATA) bit_idx_q <= 3'd0;
      else if (shift_en)      bit_idx_q <= bit_idx_q + 3'd1;
      if (shift_en) data_q <= {line_s, data_q[7:1]};
      done_q <= done_set;
      err_q  <= err_set;
    end
  end

  assign byte_data = data_q;
  assign byte_done = done_q;
  assign byte_err  = err_q;
  assign busy      = (state_q != RX_IDLE);

endmodule

// File: rtl/uart_rx_bb.sv
// uart_rx_bb: receives {id, chk} command frames over 8N1 UART and delivers
// cmd_id with a one-cycle cmd_valid when chk == id + CHK_OFFSET (mod 256).
// frame_err pulses on a bad stop bit, a check mismatch or an id->chk gap timeout.
// Optional: define BB_RX_ERR_CNT_EN to add a saturating err_cnt[7:0] output.
module uart_rx_bb
  import bb_cmd_pkg::*;
#(
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         BAUD       = 9600,
  parameter logic [7:0] CHK_OFFSET = CHK_OFFSET_DEF,
  parameter int         GAP_BITS   = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_rx,
  output logic [7:0] cmd_id,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       busy
`ifdef BB_RX_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int BIT_CNT   = CLK_FREQ / BAUD;
  localparam int GAP_LIMIT = GAP_BITS * BIT_CNT;
  localparam int GW        = $clog2(GAP_LIMIT + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LIMIT - 1);

  logic [7:0]   byte_data;
  logic         byte_done;
  logic         byte_err;
  logic         byte_busy;
  frame_state_e fr_q;
  frame_state_e fr_d;
  logic [GW-1:0] gap_cnt_q;
  logic [7:0]   id_q;
  logic [7:0]   chk_exp;
  logic [7:0]   cmd_id_q;
  logic         cmd_valid_q;
  logic         frame_err_q;
  logic         gap_to;
  logic         latch_id;
  logic         valid_set;
  logic         err_set;

  uart_rx_byte #(
    .BIT_CNT (BIT_CNT)
  ) u_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_rx   (line_rx),
    .byte_data (byte_data),
    .byte_done (byte_done),
    .byte_err  (byte_err),
    .busy      (byte_busy)
  );

  assign chk_exp = id_q + CHK_OFFSET;
  assign gap_to  = (fr_q == FR_WAIT_CHK) && !byte_busy && (gap_cnt_q == GAP_LAST);

  // Frame FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fr_q <= FR_WAIT_ID;
    else        fr_q <= fr_d;
  end

  // Frame FSM next state: a byte error or a finished/timed-out check phase restarts the frame.
  always_comb begin
    fr_d = fr_q;
    if (byte_err) begin
      fr_d = FR_WAIT_ID;
    end else begin
      case (fr_q)
        FR_WAIT_ID:  if (byte_done) fr_d = FR_WAIT_CHK;
        FR_WAIT_CHK: if (byte_done || gap_to) fr_d = FR_WAIT_ID;
        default:     fr_d = FR_WAIT_ID;
      endcase
    end
  end

  // Frame FSM outputs: latch the id, accept a matching check byte, or flag an error.
  always_comb begin
    latch_id  = 1'b0;
    valid_set = 1'b0;
    err_set   = 1'b0;
    if (byte_err) begin
      err_set = 1'b1;
    end else begin
      case (fr_q)
        FR_WAIT_ID: latch_id = byte_done;
        FR_WAIT_CHK: begin
          if (byte_done) begin
            valid_set = (byte_data == chk_exp);
            err_set   = (byte_data != chk_exp);
          end else begin
            err_set = gap_to;
          end
        end
        default: ;
      endcase
    end
  end

  // Idle-gap counter: runs only while waiting for the check byte and the line is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   gap_cnt_q <= '0;
    else if (fr_q != FR_WAIT_CHK) gap_cnt_q <= '0;
    else if (!byte_busy)          gap_cnt_q <= gap_cnt_q + GW'(1);
  end

  // Registered frame results; valid and error come from exclusive branches above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q        <= 8'h00;
      cmd_id_q    <= 8'h00;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (latch_id)  id_q     <= byte_data;
      if (valid_set) cmd_id_q <= id_q;
      cmd_valid_q <= valid_set;
      frame_err_q <= err_set;
    end
  end

  assign cmd_id    = cmd_id_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = byte_busy | (fr_q == FR_WAIT_CHK);

`ifdef BB_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of frame_err pulses since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               err_cnt_q <= 8'h00;
    else if (frame_err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_bb.sv
// tb_uart_rx_bb: directed plus randomized frames against a frame-level model.
// Runs at 8 clocks per bit to keep the run short; BB_RX_ERR_CNT_EN enables the err_cnt checks.
module tb_uart_rx_bb;

  localparam int         CLK_FREQ = 800_000;
  localparam int         BAUD     = 100_000;
  localparam int         BIT_CNT  = CLK_FREQ / BAUD;
  localparam int         GAP_BITS = 20;
  localparam logic [7:0] OFF      = 8'hB3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       line_rx;
  logic [7:0] cmd_id;
  logic       cmd_valid;
  logic       frame_err;
  logic       busy;
`ifdef BB_RX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  uart_rx_bb #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .CHK_OFFSET (OFF),
    .GAP_BITS   (GAP_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_rx   (line_rx),
    .cmd_id    (cmd_id),
    .cmd_valid (cmd_valid),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef BB_RX_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Observed pulse history, sampled on the falling edge.
  int         cyc = 0;
  int         obs_valid = 0;
  int         obs_err = 0;
  int         last_valid_cyc = 0;
  logic [7:0] last_valid_id = 8'h00;
  bit         both_seen = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cmd_valid) begin
      obs_valid      = obs_valid + 1;
      last_valid_cyc = cyc;
      last_valid_id  = cmd_id;
    end
    if (frame_err) obs_err = obs_err + 1;
    if (cmd_valid && frame_err) both_seen = 1'b1;
  end

  // Frame-level reference model.
  int         exp_valid = 0;
  int         exp_err = 0;
  int         exp_err_rst = 0;
  logic [7:0] exp_id = 8'h00;
  bit         pend = 1'b0;
  logic [7:0] pend_id = 8'h00;
  int         idle_acc = 0;
  int         stop_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_err();
    exp_err     = exp_err + 1;
    exp_err_rst = exp_err_rst + 1;
    pend        = 1'b0;
  endtask

  // A pending id times out once the idle gap reaches GAP_BITS bit-times.
  task automatic model_gap();
    if (pend && idle_acc >= GAP_BITS) model_err();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    model_gap();
    if (!stop_ok) begin
      model_err();
    end else if (pend) begin
      logic [7:0] want;
      want = pend_id + OFF;
      if (b == want) begin
        exp_valid = exp_valid + 1;
        exp_id    = pend_id;
        pend      = 1'b0;
      end else begin
        model_err();
      end
    end else begin
      pend    = 1'b1;
      pend_id = b;
    end
    idle_acc = 0;
  endtask

  task automatic idle_bits(input int n);
    line_rx = 1'b1;
    repeat (n * BIT_CNT) @(posedge clk);
    idle_acc = idle_acc + n;
    model_gap();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      line_rx = fr[i];
      if (i == 9) stop_cyc = cyc;
      repeat (BIT_CNT) @(posedge clk);
    end
    line_rx = 1'b1;
    model_byte(b, stop_ok);
  endtask

  task automatic check_frame(input string tag);
    idle_bits(2);
    #1;
    check({tag, "_valid_cnt"}, obs_valid, exp_valid);
    check({tag, "_err_cnt"}, obs_err, exp_err);
    check({tag, "_cmd_id"}, cmd_id, exp_id);
`ifdef BB_RX_ERR_CNT_EN
    check({tag, "_err_cnt_out"}, err_cnt, (exp_err_rst > 255) ? 255 : exp_err_rst);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_id"}, cmd_id, 8'h00);
    check({tag, "_cmd_valid"}, cmd_valid, 1'b0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
`ifdef BB_RX_ERR_CNT_EN
    check({tag, "_err_cnt_out"}, err_cnt, 8'h00);
`endif
  endtask

  initial begin
    logic [7:0] id;
    logic [7:0] chk;
    logic [9:0] fr;
    int         mode;
    int         lat;

    // Reset state.
    line_rx = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);

    // Back-to-back good frame, with delivery latency near the chk stop-bit centre.
    send_byte(8'h05, 1'b1);
    send_byte(8'hB8, 1'b1);
    check_frame("t1");
    lat = last_valid_cyc - stop_cyc;
    check("t1_latency_in_window", (lat >= BIT_CNT / 2 && lat <= BIT_CNT + 4), 1'b1);
    check("t1_pulse_id", last_valid_id, 8'h05);

    // Check mismatch: error, cmd_id keeps 8'h05.
    send_byte(8'h03, 1'b1);
    send_byte(8'hB7, 1'b1);
    check_frame("t2");

    // Gap timeout; the late byte becomes a new id, proven by its own matching chk.
    send_byte(8'h01, 1'b1);
    idle_bits(21);
    send_byte(8'hB4, 1'b1);
    check_frame("t3_timeout");
    send_byte(8'h67, 1'b1);
    check_frame("t3_new_id");

    // Short low glitch on the idle line: start seen, then rejected silently.
    @(posedge clk);
    line_rx = 1'b0;
    repeat (2) @(posedge clk);
    line_rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t4_busy_during_glitch", busy, 1'b1);
    idle_bits(3);
    #1;
    check("t4_busy_after_glitch", busy, 1'b0);
    check_frame("t4_glitch");
    send_byte(8'h02, 1'b1);
    send_byte(8'hB5, 1'b1);
    check_frame("t4_after");

    // Line break: one error only, and no new start until the line goes high.
    line_rx = 1'b0;
    repeat (15 * BIT_CNT) @(posedge clk);
    line_rx = 1'b1;
    model_byte(8'h00, 1'b0);
    check_frame("break");

    // Reset in the middle of the chk byte aborts the frame.
    send_byte(8'h04, 1'b1);
    fr = {1'b1, 8'hB7, 1'b0};
    for (int i = 0; i < 5; i++) begin
      line_rx = fr[i];
      repeat (BIT_CNT) @(posedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t5_in_reset");
    line_rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    pend        = 1'b0;
    exp_id      = 8'h00;
    exp_err_rst = 0;
    idle_acc    = 0;
    check_frame("t5_released");
    send_byte(8'h04, 1'b1);
    send_byte(8'hB7, 1'b1);
    check_frame("t5_after");

`ifdef BB_RX_ERR_CNT_EN
    // Many bad-chk frames drive the error counter into saturation.
    for (int n = 0; n < 300; n++) begin
      id  = 8'($urandom);
      chk = id + OFF + 8'(1 + $urandom_range(0, 254));
      send_byte(id, 1'b1);
      send_byte(chk, 1'b1);
    end
    check_frame("t6_saturate");
`endif

    // Check byte wrapping through zero.
    send_byte(8'h4D, 1'b1);
    send_byte(8'h00, 1'b1);
    check_frame("wrap");

    // Randomized frames: good, bad chk, bad stop on either byte, or a long gap.
    for (int n = 0; n < 24; n++) begin
      mode = $urandom_range(0, 4);
      id   = 8'($urandom);
      chk  = id + OFF;
      if (mode == 1) chk = chk ^ 8'(1 << $urandom_range(0, 7));
      send_byte(id, (mode != 2));
      if (mode == 4) idle_bits($urandom_range(24, 27));
      else if ($urandom_range(0, 1) == 1) idle_bits($urandom_range(1, 12));
      send_byte(chk, (mode != 3));
      check_frame($sformatf("rnd%0d_m%0d", n, mode));
    end
    idle_bits(25);
    check_frame("final_flush");
    check("valid_err_exclusive", both_seen, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
